// File: rtl/bm_dl_simple_seq_gen.sv
// bm_dl_simple_seq_gen: serial frame transmitter for the w-run detector, with cycle-exact predicted z
module bm_dl_simple_seq_gen #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             busy,
  output logic             w,
  output logic             done,
  output logic             z_exp
);
  localparam int BW = $clog2(WIDTH);
  localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_SHIFT = 2'b01, S_GAP = 2'b10} state_t;
  state_t           state, nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             w_d;
  always_ff @(posedge Clock) state <= !Resetn ? S_IDLE : nxt;
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:  nxt = start ? S_SHIFT : S_IDLE;
      S_SHIFT: nxt = bit_cnt != '0 ? S_SHIFT : (GAP > 0 ? S_GAP : S_IDLE);
      S_GAP:   nxt = gap_cnt != '0 ? S_GAP : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    ready = state == S_IDLE;
    busy  = state == S_SHIFT || state == S_GAP;
    done  = state == S_SHIFT && bit_cnt == '0;
  end
  // w and z_exp are registered; z_exp looks at the two previous w values
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      w       <= 1'b0;
      w_d     <= 1'b0;
      z_exp   <= 1'b0;
    end else begin
      w_d   <= w;
      z_exp <= w & w_d;
      if (state == S_IDLE && start) begin
        shreg   <= data;
        bit_cnt <= BW'(WIDTH - 1);
        w       <= MSB_FIRST ? data[WIDTH-1] : data[0];
      end else if (state == S_SHIFT && bit_cnt != '0) begin
        shreg   <= MSB_FIRST ? shreg << 1 : shreg >> 1;
        bit_cnt <= bit_cnt - 1'b1;
        w       <= MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
      end else begin
        w       <= 1'b0;
        gap_cnt <= done ? GW'(GAP > 0 ? GAP - 1 : 0) : (state == S_GAP ? gap_cnt - 1'b1 : gap_cnt);
      end
    end
  end
endmodule

// File: tb/tb_bm_dl_simple_seq_gen.sv
// tb_bm_dl_simple_seq_gen: vector table, directed corner sequences and random stimulus against a frame-queue model
module tb_bm_dl_simple_seq_gen;
  logic Clock = 1'b0, Resetn = 1'b0, start = 1'b0, startb = 1'b0;
  logic [7:0] data = '0, datab = '0;
  logic ready, busy, w, done, z_exp;
  logic readyb, busyb, wb, doneb, zb;
  int n_chk = 0, n_fail = 0;
  always #5 Clock = ~Clock;
  bm_dl_simple_seq_gen #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .data(data),
    .ready(ready), .busy(busy), .w(w), .done(done), .z_exp(z_exp));
  bm_dl_simple_seq_gen #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) dutb (
    .Clock(Clock), .Resetn(Resetn), .start(startb), .data(datab),
    .ready(readyb), .busy(busyb), .w(wb), .done(doneb), .z_exp(zb));
  typedef struct {logic rstn, st; logic [7:0] d; logic w, done, z, rdy, busy;} vec_t;
  vec_t tv[13];
  logic [1:0] q[$];
  logic mw = 0, mw1 = 0, mz = 0, mready = 1, mbusy = 0, mdone = 0;
  task automatic chk(input string n, input logic a, input logic b);
    n_chk++;
    if (a !== b) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", n, a, b, $time);
    end
  endtask
  // model: an accepted frame becomes WIDTH bits plus GAP zeros queued for w
  task automatic step();
    logic [1:0] e;
    @(posedge Clock);
    if (!Resetn) begin
      q.delete();
      {mw, mw1, mz, mbusy, mdone} = '0;
      mready = 1'b1;
    end else begin
      if (mready && start)
        for (int i = 0; i < 10; i++) q.push_back(i < 8 ? {i == 7, data[7-i]} : 2'b00);
      mz  = mw & mw1;
      mw1 = mw;
      if (q.size() != 0) begin
        e = q.pop_front();
        {mdone, mw} = e;
        mbusy  = 1'b1;
        mready = 1'b0;
      end else begin
        {mw, mdone, mbusy} = '0;
        mready = 1'b1;
      end
    end
    @(negedge Clock);
    chk("m_w", w, mw);
    chk("m_done", done, mdone);
    chk("m_z", z_exp, mz);
    chk("m_ready", ready, mready);
    chk("m_busy", busy, mbusy);
  endtask
  initial begin
    tv[0]  = '{0, 1, 8'hFF, 0, 0, 0, 1, 0};
    tv[1]  = '{0, 0, 8'h00, 0, 0, 0, 1, 0};
    tv[2]  = '{1, 1, 8'hB6, 1, 0, 0, 0, 1};
    tv[3]  = '{1, 0, 8'h5A, 0, 0, 0, 0, 1};
    tv[4]  = '{1, 0, 8'h5A, 1, 0, 0, 0, 1};
    tv[5]  = '{1, 0, 8'h5A, 1, 0, 0, 0, 1};
    tv[6]  = '{1, 0, 8'h5A, 0, 0, 1, 0, 1};
    tv[7]  = '{1, 0, 8'h5A, 1, 0, 0, 0, 1};
    tv[8]  = '{1, 0, 8'h5A, 1, 0, 0, 0, 1};
    tv[9]  = '{1, 0, 8'h5A, 0, 1, 1, 0, 1};
    tv[10] = '{1, 0, 8'h5A, 0, 0, 0, 0, 1};
    tv[11] = '{1, 0, 8'h5A, 0, 0, 0, 0, 1};
    tv[12] = '{1, 0, 8'h5A, 0, 0, 0, 1, 0};
    foreach (tv[i]) begin
      Resetn = tv[i].rstn;
      start  = tv[i].st;
      data   = tv[i].d;
      step();
      chk("tv_w", w, tv[i].w);
      chk("tv_done", done, tv[i].done);
      chk("tv_z", z_exp, tv[i].z);
      chk("tv_ready", ready, tv[i].rdy);
      chk("tv_busy", busy, tv[i].busy);
    end
    start = 1; data = 8'hFF;
    for (int c = 1; c <= 11; c++) begin
      step();
      start = 0;
      chk("ff_z", z_exp, c >= 3 && c <= 9);
      chk("ff_w", w, c <= 8);
    end
    start = 1; data = 8'hA5;
    for (int c = 1; c <= 10; c++) begin
      step();
      start = (c == 2 || c == 8 || c == 10);
      data  = 8'h00;
    end
    step();
    chk("held_ready", ready, 1'b1);
    step();
    chk("held_busy", busy, 1'b1);
    start = 0;
    repeat (10) step();
    start = 1; data = 8'hFF;
    step();
    start = 0;
    repeat (3) step();
    Resetn = 0;
    step();
    chk("rst_w", w, 1'b0);
    chk("rst_z", z_exp, 1'b0);
    chk("rst_ready", ready, 1'b1);
    Resetn = 1;
    repeat (12) begin
      step();
      chk("rst_done", done, 1'b0);
    end
    startb = 1; datab = 8'h01;
    for (int c = 1; c <= 18; c++) begin
      step();
      datab = 8'hFF;
      if (c == 17) startb = 0;
      chk("g0_w", wb, c == 1 || (c >= 10 && c <= 17));
      chk("g0_done", doneb, c == 8 || c == 17);
      if (c == 9 || c == 18) chk("g0_ready", readyb, 1'b1);
    end
    repeat (400) begin
      Resetn = $urandom_range(0, 40) != 0;
      start  = $urandom_range(0, 3) == 0;
      data   = 8'($urandom);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
